// File: rtl/div_pkg.sv
// div_pkg: shared widths, state encoding and saturation limits for the signed divider
package div_pkg;
    localparam int W = 8;
    localparam int WD = 2 * W;
    localparam int ITERS = WD;
    localparam int CW = $clog2(ITERS);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
    localparam logic [W-1:0] Q_MAX = 8'h7F;
    localparam logic [W-1:0] Q_MIN = 8'h80;
endpackage

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: start/done operand and result bundle for the divider
interface seq_signed_divider_if
    import div_pkg::*;
();
    logic start;
    logic [WD-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic busy;
    logic done;
    logic div0;
    logic ovf;
    modport master (
        output start, dividend, divisor,
        input quotient, remainder, busy, done, div0, ovf
    );
    modport slave (
        input start, dividend, divisor,
        output quotient, remainder, busy, done, div0, ovf
    );
endinterface

// File: rtl/sgn_mag.sv
// sgn_mag: absolute value or conditional negate, one bit wider so the most negative input is exact
module sgn_mag #(
    parameter int N = 8
) (
    input logic [N-1:0] x,
    input logic sext,
    input logic neg,
    output logic [N:0] y
);
    logic [N:0] e;
    // extend as signed or unsigned, then negate when asked
    always_comb begin
        e = {sext & x[N-1], x};
        y = neg ? -e : e;
    end
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: 16/8 signed restoring divider, one quotient bit per cycle, then sign fix-up
module seq_signed_divider
    import div_pkg::*;
(
    input logic clk,
    input logic reset,
    seq_signed_divider_if.slave bus
);
    div_state_t state;
    logic [CW-1:0] cnt;
    logic [WD-1:0] q;
    logic [W:0] rem;
    logic [W:0] dmag;
    logic [W:0] dsr_abs;
    logic [W:0] r_s;
    logic [WD:0] dvd_abs;
    logic [WD:0] q_s;
    logic [W+1:0] rem_sh;
    logic [W+1:0] trial;
    logic [W-1:0] dlo;
    logic neg_n;
    logic neg_d;
    logic q_fit;
    logic unused_bits;

    sgn_mag #(.N(WD)) u_dvd (.x(bus.dividend), .sext(1'b1), .neg(bus.dividend[WD-1]), .y(dvd_abs));
    sgn_mag #(.N(W)) u_dsr (.x(bus.divisor), .sext(1'b1), .neg(bus.divisor[W-1]), .y(dsr_abs));
    sgn_mag #(.N(WD)) u_quo (.x(q), .sext(1'b0), .neg(neg_n ^ neg_d), .y(q_s));
    sgn_mag #(.N(W)) u_rem (.x(rem[W-1:0]), .sext(1'b0), .neg(neg_n), .y(r_s));

    // trial subtraction of the shifted partial remainder; the top bit of trial is its sign
    always_comb begin
        rem_sh = {rem, q[WD-1]};
        trial = rem_sh - {1'b0, dmag};
        q_fit = (&q_s[WD:W-1]) | ~(|q_s[WD:W-1]);
        unused_bits = ^{dvd_abs[WD], r_s[W], rem_sh[W+1]};
    end

    // control FSM: latch magnitudes, iterate 16 times, fix signs and flags, then hold results
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            q <= '0;
            rem <= '0;
            dmag <= '0;
            dlo <= '0;
            neg_n <= 1'b0;
            neg_d <= 1'b0;
            bus.quotient <= '0;
            bus.remainder <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            bus.ovf <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        neg_n <= bus.dividend[WD-1];
                        neg_d <= bus.divisor[W-1];
                        q <= dvd_abs[WD-1:0];
                        dmag <= dsr_abs;
                        dlo <= bus.dividend[W-1:0];
                        rem <= '0;
                        cnt <= '0;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    q <= {q[WD-2:0], ~trial[W+1]};
                    rem <= trial[W+1] ? rem_sh[W:0] : trial[W:0];
                    cnt <= cnt + 1'b1;
                    state <= (cnt == CW'(ITERS - 1)) ? FIX : ITER;
                end
                FIX: begin
                    bus.div0 <= (dmag == '0);
                    bus.ovf <= (dmag != '0) & ~q_fit;
                    bus.quotient <= (dmag == '0) ? {W{1'b1}} :
                                    q_fit ? q_s[W-1:0] : (q_s[WD] ? Q_MIN : Q_MAX);
                    bus.remainder <= (dmag == '0) ? dlo : r_s[W-1:0];
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random checks of the signed divider against SV / and %
module tb_seq_signed_divider;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    seq_signed_divider_if bus();
    seq_signed_divider dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: {div0, ovf, quotient, remainder}
    function automatic logic [17:0] model(input logic signed [15:0] a, input logic signed [7:0] d);
        int qi;
        int ri;
        logic [7:0] qb;
        logic o;
        if (d == 0) return {1'b1, 1'b0, 8'hFF, a[7:0]};
        qi = int'(a) / int'(d);
        ri = int'(a) % int'(d);
        o = (qi > 127) || (qi < -128);
        qb = o ? ((qi > 0) ? 8'h7F : 8'h80) : qi[7:0];
        return {1'b0, o, qb, ri[7:0]};
    endfunction

    task automatic check_result(input string tag, input logic signed [15:0] a, input logic signed [7:0] d);
        logic [17:0] e;
        e = model(a, d);
        chk({tag, ".quo"}, 32'(bus.quotient), 32'(e[15:8]));
        chk({tag, ".rem"}, 32'(bus.remainder), 32'(e[7:0]));
        chk({tag, ".div0"}, 32'(bus.div0), 32'(e[17]));
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(e[16]));
    endtask

    task automatic do_op(input string tag, input logic signed [15:0] a, input logic signed [7:0] d, input int pulse_at);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = d;
        @(posedge clk);
        #1;
        chk({tag, ".accept_done_low"}, 32'(bus.done), 32'd0);
        chk({tag, ".accept_busy"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 8'($urandom);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (lat == pulse_at) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.dividend = -16'sd1234;
                bus.divisor = 8'sd3;
            end else if (lat == pulse_at + 1) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd17);
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        check_result(tag, a, d);
    endtask

    initial begin
        logic [7:0] hq;
        logic [7:0] hr;
        logic signed [15:0] ra;
        logic signed [7:0] rd;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.quo", 32'(bus.quotient), 32'd0);
        chk("rst.rem", 32'(bus.remainder), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.div0", 32'(bus.div0), 32'd0);
        chk("rst.ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op("p30_6", 16'sd30, 8'sd6, -5);
        hq = bus.quotient;
        hr = bus.remainder;
        repeat (5) @(posedge clk);
        #1;
        chk("hold.quo", 32'(bus.quotient), 32'(hq));
        chk("hold.rem", 32'(bus.remainder), 32'(hr));
        chk("hold.done", 32'(bus.done), 32'd1);
        do_op("m35_7", -16'sd35, 8'sd7, -5);
        do_op("m31_6", -16'sd31, 8'sd6, -5);
        do_op("p31_m6", 16'sd31, -8'sd6, -5);
        do_op("m31_m6", -16'sd31, -8'sd6, -5);
        do_op("p16384_m128", 16'sd16384, -8'sd128, -5);
        do_op("m32768_m1", -16'sd32768, -8'sd1, -5);
        do_op("p1000_2", 16'sd1000, 8'sd2, -5);
        do_op("m32768_m128", -16'sd32768, -8'sd128, -5);
        do_op("p100_0", 16'sd100, 8'sd0, -5);
        do_op("pulse_mid", 16'sd30, 8'sd6, 5);
        do_op("p100_0b", 16'sd100, 8'sd0, -5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'sd30;
        bus.divisor = 8'sd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.quo", 32'(bus.quotient), 32'd0);
        chk("midrst.rem", 32'(bus.remainder), 32'd0);
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk("midrst.div0", 32'(bus.div0), 32'd0);
        chk("midrst.ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op("after_rst", 16'sd30, 8'sd6, -5);
        for (int i = 0; i < 40; i++) begin
            ra = (i % 2 == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 8000))) - 16'sd4000);
            rd = 8'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rd, -5);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed 16/8 divider: the inverse of the team's multi-cycle signed 8x8 multiplier.
- Takes a 16-bit product-width dividend and an 8-bit divisor, and returns an 8-bit quotient and an 8-bit remainder.
- Uses radix-2 restoring division on magnitudes, followed by sign correction.
- Sits beside the multiplier in the arithmetic datapath and uses the same start/done style: operands are latched, and done is held until the next operation.

Parameters:
- W, 8: divisor, quotient and remainder width.
- WD, 2*W: dividend width (fixed relation, not independently overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  one-cycle launch request; honoured only when not busy.
- dividend  input  WD  signed dividend, sampled on the accepted start edge.
- divisor  input  W  signed divisor, sampled on the accepted start edge.
- quotient  output  W  signed quotient, truncated toward zero.
- remainder  output  W  signed remainder; its sign follows the dividend.
- busy  output  1  high while an operation is in flight.
- done  output  1  high when results are valid; held until the next accepted start.
- div0  output  1  divide-by-zero flag; valid with done.
- ovf  output  1  quotient-overflow flag; valid with done.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - quotient, remainder, busy, done, div0 and ovf all go to 0.
  - Reset overrides everything, including an operation in flight; no partial result is exposed.
- States: IDLE, ITER, FIX, DONE.
- IDLE or DONE with start==1 at edge N:
  - Latch the operand signs.
  - Latch |dividend| into a 16-bit unsigned quotient/shift register and |divisor| into a 9-bit register.
  - |-32768| = 32768 and |-128| = 128 must be exact; no wrap.
  - Clear the partial remainder (9 bits) and the iteration counter.
  - Set busy=1 and done=0; go to ITER.
- ITER, one quotient bit per cycle, 16 cycles:
  - Shift {rem, q} left 1.
  - trial = rem - dmag.
  - If trial >= 0: rem = trial and q[0] = 1; else q[0] = 0.
  - Leave ITER after counter reaches 15.
- FIX, one cycle:
  - Negate the quotient magnitude if the signs differ.
  - Negate the remainder magnitude if the dividend was negative.
  - Overflow: if the true signed quotient lies outside [-128, 127], set ovf=1 and saturate quotient to 127 (positive) or -128 (negative). The remainder is still the exact remainder.
  - Divide by zero: if divisor==0, set div0=1, quotient = 8'hFF, remainder = dividend[7:0], ovf=0. The same latency is kept; the iterations run but their result is discarded.
  - Register all outputs; busy=0, done=1; go to DONE.
- Latency: accepted start at edge N gives done=1 and valid outputs after edge N+17. The latency is fixed for all operands.
- DONE: outputs and flags hold indefinitely. start behaves as in IDLE; done drops on the edge that accepts the new start.
- start while busy (ITER or FIX) is ignored; operands are not resampled.
- Operand inputs may change freely after the accepting edge.
- Arithmetic identity: for all non-div0, non-ovf cases, quotient*divisor + remainder == dividend, with |remainder| < |divisor|. This matches SystemVerilog signed / and %.

Decomposition:
- Shared package div_pkg:
  - localparams W and WD, and ITERS = WD.
  - enum logic [1:0] div_state_t {IDLE, ITER, FIX, DONE}.
  - Saturation constants Q_MAX = 127 and Q_MIN = -128.
- One sub-module is natural: sgn_mag, a parameterised combinational absolute value / conditional negate. It has a width parameter and a one-bit-wider unsigned output so the most negative input is handled. It is instantiated for dividend, divisor, quotient and remainder.

Test Plan:
- 30 / 6 -> quotient=5, remainder=0, flags 0; done rises exactly 17 cycles after the start edge.
- -35 / 7 -> -5 r 0; -31 / 6 -> -5 r -1; 31 / -6 -> -5 r 1; -31 / -6 -> 5 r -1.
- Boundary values:
  - 16384 / -128 -> -128 r 0, ovf=0.
  - -32768 / -1 -> ovf=1, quotient=127.
  - 1000 / 2 -> ovf=1, quotient=127, remainder=0.
- 100 / 0 -> div0=1, quotient=8'hFF, remainder=8'h64, latency 17.
- Pulse start again mid-ITER with new operands -> ignored, original result delivered.
- Drive reset=0 at cycle 8 of an operation -> all outputs 0 and state IDLE on the next edge; a subsequent 30/6 completes correctly.
- Back-to-back run:
  - Start in the cycle after done for random signed pairs -> done drops for one start edge.
  - Every result equals SV / and %; outputs are stable throughout DONE.
